// File: rtl/router_fsm_pkg.sv
// Shared definitions for the 1x3 router: state encodings, port addresses and
// the per-state output decode used by the write controller.
package router_fsm_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'b000,
        LOAD_FIRST_DATA    = 3'b001,
        LOAD_DATA          = 3'b010,
        FIFO_FULL_STATE    = 3'b011,
        LOAD_AFTER_FULL    = 3'b100,
        LOAD_PARITY        = 3'b101,
        CHECK_PARITY_ERROR = 3'b110,
        WAIT_TILL_EMPTY    = 3'b111
    } state_t;

    localparam logic [1:0] ADDR_PORT0   = 2'd0;
    localparam logic [1:0] ADDR_PORT1   = 2'd1;
    localparam logic [1:0] ADDR_PORT2   = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef struct packed {
        logic detect_addr;
        logic lfd_state;
        logic ld_state;
        logic full_state;
        logic laf_state;
        logic write_enb_reg;
        logic rst_int_reg;
        logic busy;
    } fsm_out_t;

    // Picks the per-port flag addressed by addr; the invalid address selects nothing.
    function automatic logic port_sel(input logic [2:0] flags, input logic [1:0] addr);
        logic r;
        case (addr)
            ADDR_PORT0: r = flags[0];
            ADDR_PORT1: r = flags[1];
            ADDR_PORT2: r = flags[2];
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic fsm_out_t decode_outputs(input state_t s);
        fsm_out_t o;
        o = '0;
        case (s)
            DECODE_ADDRESS:     o.detect_addr = 1'b1;
            LOAD_FIRST_DATA:    begin o.lfd_state = 1'b1; o.busy = 1'b1; end
            LOAD_DATA:          begin o.ld_state = 1'b1; o.write_enb_reg = 1'b1; end
            FIFO_FULL_STATE:    begin o.full_state = 1'b1; o.busy = 1'b1; end
            LOAD_AFTER_FULL:    begin o.laf_state = 1'b1; o.write_enb_reg = 1'b1; o.busy = 1'b1; end
            LOAD_PARITY:        begin o.write_enb_reg = 1'b1; o.busy = 1'b1; end
            CHECK_PARITY_ERROR: begin o.rst_int_reg = 1'b1; o.busy = 1'b1; end
            WAIT_TILL_EMPTY:    o.busy = 1'b1;
            default:            o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-level write controller for the 1x3 router: decodes the header address,
// sequences header/payload/parity phases and stalls on a full destination FIFO.
module router_fsm
    import router_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_addr,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       full_state,
    output logic       laf_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output logic [2:0] state_dbg
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_addr_q;
    fsm_out_t   r_out;

    logic [2:0] w_empty;
    logic [2:0] w_soft;
    logic       w_sel_empty;
    logic       w_sel_soft;
    logic       w_hdr_ok;

    assign w_empty     = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign w_soft      = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign w_sel_empty = port_sel(w_empty, r_addr_q);
    assign w_sel_soft  = port_sel(w_soft, r_addr_q);
    assign w_hdr_ok    = pkt_valid && (data_in != ADDR_INVALID);

    always_comb begin
        w_next = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                // The address is not latched yet, so the empty test looks at data_in.
                if (w_hdr_ok)
                    w_next = port_sel(w_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: w_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       w_next = FIFO_FULL_STATE;
                else if (!pkt_valid) w_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) w_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        w_next = DECODE_ADDRESS;
                else if (low_pkt_valid) w_next = LOAD_PARITY;
                else                    w_next = LOAD_DATA;
            end
            LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (w_sel_empty) w_next = LOAD_FIRST_DATA;
            end
            default: w_next = DECODE_ADDRESS;
        endcase
        // A read timeout on the destination port abandons the packet from any phase.
        if (r_state != DECODE_ADDRESS && w_sel_soft)
            w_next = DECODE_ADDRESS;
    end

    // Outputs are registered from the next state so they stay a pure function of state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= DECODE_ADDRESS;
            r_addr_q <= ADDR_PORT0;
            r_out    <= decode_outputs(DECODE_ADDRESS);
        end else begin
            r_state <= w_next;
            r_out   <= decode_outputs(w_next);
            if (r_state == DECODE_ADDRESS && w_next != DECODE_ADDRESS)
                r_addr_q <= data_in;
        end
    end

    assign detect_addr   = r_out.detect_addr;
    assign lfd_state     = r_out.lfd_state;
    assign ld_state      = r_out.ld_state;
    assign full_state    = r_out.full_state;
    assign laf_state     = r_out.laf_state;
    assign write_enb_reg = r_out.write_enb_reg;
    assign rst_int_reg   = r_out.rst_int_reg;
    assign busy          = r_out.busy;
    assign state_dbg     = r_state;

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: per-scenario stimulus tables, an expected
// output queue filled when inputs are driven and drained one cycle later.
module tb_router_fsm;

    // Output vector order: detect, lfd, ld, full, laf, wen, rst_int, busy
    localparam logic [7:0] S_DA  = 8'b1000_0000;
    localparam logic [7:0] S_LFD = 8'b0100_0001;
    localparam logic [7:0] S_LD  = 8'b0010_0100;
    localparam logic [7:0] S_FUL = 8'b0001_0001;
    localparam logic [7:0] S_LAF = 8'b0000_1101;
    localparam logic [7:0] S_LP  = 8'b0000_0101;
    localparam logic [7:0] S_CPE = 8'b0000_0011;
    localparam logic [7:0] S_WTE = 8'b0000_0001;
    localparam logic [2:0] E     = 3'b111;

    typedef struct packed {
        logic       pv;
        logic [1:0] din;
        logic       full;
        logic [2:0] emp;
        logic [2:0] srst;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       detect_addr, lfd_state, ld_state, full_state, laf_state;
    logic       write_enb_reg, rst_int_reg, busy;
    logic [2:0] state_dbg;
    logic [7:0] w_obs;

    always #5 clk = ~clk;

    router_fsm dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy), .state_dbg(state_dbg)
    );

    assign w_obs = {detect_addr, lfd_state, ld_state, full_state, laf_state,
                    write_enb_reg, rst_int_reg, busy};

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    function automatic vec_t v(input logic pv, input logic [1:0] din, input logic full,
                               input logic [2:0] emp, input logic [2:0] srst,
                               input logic pd, input logic lpv, input logic [7:0] exp);
        vec_t r;
        r.pv = pv; r.din = din; r.full = full; r.emp = emp;
        r.srst = srst; r.pd = pd; r.lpv = lpv; r.exp = exp;
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input vec_t x);
        pkt_valid     = x.pv;
        data_in       = x.din;
        fifo_full     = x.full;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = x.emp;
        {soft_reset_2, soft_reset_1, soft_reset_0} = x.srst;
        parity_done   = x.pd;
        low_pkt_valid = x.lpv;
        exp_q.push_back(x.exp);
    endtask

    task automatic idle();
        pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = E;
        {soft_reset_2, soft_reset_1, soft_reset_0} = 3'b000;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        vec_t       seq[$];
        logic [7:0] exp;
        idle();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        exp_q.push_back(S_DA);
        #1;
        exp = exp_q.pop_front();
        n_vec++;
        if (w_obs !== exp) begin
            n_err++;
            $display("FAIL reset_idle: got %b want %b", w_obs, exp);
        end
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LFD));
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LD));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_vec++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL reset_pkt[%0d]: got %b want %b", i, w_obs, exp);
            end
        end
        // Abort mid-payload: outputs must return to idle before the next edge.
        #3 resetn = 1'b0;
        exp_q.push_back(S_DA);
        #1;
        exp = exp_q.pop_front();
        n_vec++;
        if (w_obs !== exp) begin
            n_err++;
            $display("FAIL reset_async: got %b want %b", w_obs, exp);
        end
        exp_q.push_back(S_DA);
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        n_vec++;
        if (w_obs !== exp || state_dbg !== 3'b000) begin
            n_err++;
            $display("FAIL reset_held: got %b/%0d want %b/0", w_obs, state_dbg, exp);
        end
        idle();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_normal();
        vec_t       seq[$];
        logic [7:0] exp;
        seq.push_back(v(1, 2'd2, 0, E, 3'b000, 0, 0, S_LFD));
        seq.push_back(v(1, 2'd2, 0, E, 3'b000, 0, 0, S_LD));
        for (int k = 0; k < 3; k++)
            seq.push_back(v(1, 2'd2, 0, E, 3'b000, 0, 0, S_LD));
        seq.push_back(v(0, 2'd2, 0, E, 3'b000, 0, 0, S_LP));
        seq.push_back(v(0, 2'd2, 0, E, 3'b000, 0, 0, S_CPE));
        seq.push_back(v(0, 2'd2, 0, E, 3'b000, 0, 0, S_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_vec++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL normal[%0d]: got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    task automatic test_invalid_addr();
        vec_t       seq[$];
        logic [7:0] exp;
        for (int k = 0; k < 10; k++)
            seq.push_back(v(1, 2'd3, 0, 3'($urandom_range(0, 7)), 3'b000, 0, 0, S_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_vec++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL invalid_addr[%0d]: got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    task automatic test_busy_dest();
        vec_t       seq[$];
        logic [7:0] exp;
        seq.push_back(v(1, 2'd1, 0, 3'b101, 3'b000, 0, 0, S_WTE));
        // data_in wanders to an empty port; the latched address must still rule.
        for (int k = 0; k < 5; k++)
            seq.push_back(v(1, 2'd2, 0, 3'b101, 3'b000, 0, 0, S_WTE));
        seq.push_back(v(1, 2'd2, 0, E, 3'b000, 0, 0, S_LFD));
        seq.push_back(v(1, 2'd2, 0, E, 3'b000, 0, 0, S_LD));
        seq.push_back(v(0, 2'd2, 0, E, 3'b000, 0, 0, S_LP));
        seq.push_back(v(0, 2'd2, 0, E, 3'b000, 0, 0, S_CPE));
        seq.push_back(v(0, 2'd2, 0, E, 3'b000, 0, 0, S_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_vec++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL busy_dest[%0d]: got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    task automatic test_full_stall();
        vec_t       seq[$];
        logic [7:0] exp;
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LFD));
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LD));
        for (int k = 0; k < 3; k++)
            seq.push_back(v(1, 2'd0, 1, E, 3'b000, 0, 0, S_FUL));
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LAF));
        seq.push_back(v(0, 2'd0, 0, E, 3'b000, 0, 1, S_LP));
        seq.push_back(v(0, 2'd0, 0, E, 3'b000, 0, 0, S_CPE));
        seq.push_back(v(0, 2'd0, 0, E, 3'b000, 0, 0, S_DA));
        // Full and end-of-packet together, LAF back to LD, parity check into full.
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LFD));
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LD));
        seq.push_back(v(0, 2'd0, 1, E, 3'b000, 0, 0, S_FUL));
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LAF));
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LD));
        seq.push_back(v(0, 2'd0, 0, E, 3'b000, 0, 0, S_LP));
        seq.push_back(v(0, 2'd0, 0, E, 3'b000, 0, 0, S_CPE));
        seq.push_back(v(0, 2'd0, 1, E, 3'b000, 0, 0, S_FUL));
        seq.push_back(v(0, 2'd0, 0, E, 3'b000, 0, 0, S_LAF));
        seq.push_back(v(0, 2'd0, 0, E, 3'b000, 1, 1, S_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_vec++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL full_stall[%0d]: got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    task automatic test_soft_reset();
        vec_t       seq[$];
        logic [7:0] exp;
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LFD));
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LD));
        seq.push_back(v(1, 2'd0, 1, E, 3'b000, 0, 0, S_FUL));
        seq.push_back(v(1, 2'd0, 1, E, 3'b010, 0, 0, S_FUL));
        seq.push_back(v(1, 2'd0, 1, E, 3'b110, 0, 0, S_FUL));
        seq.push_back(v(1, 2'd0, 1, E, 3'b001, 0, 0, S_DA));
        seq.push_back(v(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, S_WTE));
        seq.push_back(v(0, 2'd2, 0, E, 3'b100, 0, 0, S_DA));
        seq.push_back(v(1, 2'd1, 0, E, 3'b000, 0, 0, S_LFD));
        seq.push_back(v(0, 2'd1, 0, E, 3'b010, 0, 0, S_DA));
        seq.push_back(v(1, 2'd0, 0, E, 3'b001, 0, 0, S_LFD));
        seq.push_back(v(1, 2'd0, 0, E, 3'b000, 0, 0, S_LD));
        seq.push_back(v(0, 2'd0, 0, E, 3'b000, 0, 0, S_LP));
        seq.push_back(v(0, 2'd0, 0, E, 3'b000, 0, 0, S_CPE));
        seq.push_back(v(0, 2'd0, 0, E, 3'b000, 0, 0, S_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_vec++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL soft_reset[%0d]: got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t       seq[$];
        logic [7:0] exp;
        int         n;
        for (int p = 0; p < 3; p++) begin
            n = $urandom_range(1, 5);
            seq.push_back(v(1, 2'(p), 0, E, 3'b000, 0, 0, S_LFD));
            seq.push_back(v(1, 2'(p), 0, E, 3'b000, 0, 0, S_LD));
            for (int k = 1; k < n; k++)
                seq.push_back(v(1, 2'(p), 0, E, 3'b000, 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), S_LD));
            seq.push_back(v(0, 2'(p), 0, E, 3'b000, 0, 0, S_LP));
            seq.push_back(v(0, 2'(p), 0, E, 3'b000, 0, 0, S_CPE));
            seq.push_back(v(1, 2'((p + 1) % 3), 0, E, 3'b000, 0, 0, S_DA));
        end
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_vec++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_normal();
        test_invalid_addr();
        test_busy_dest();
        test_full_stall();
        test_soft_reset();
        test_back_to_back();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-level write controller for the 1x3 router. Sits between the register/parity stage and the synchronizer: decodes the 2-bit header address, drives `detect_addr` and `write_enb_reg` into the synchronizer, reacts to its `fifo_full` and `soft_reset_*` outputs, and sequences header, payload, parity and parity-check phases. It is a Moore machine with a latched destination address.

## Interface
- No parameters. State encoding and address constants come from the shared defines.
- `clk` in 1: single clock; all state changes on the rising edge.
- `resetn` in 1: reset is asynchronous and active-low.
- `pkt_valid` in 1: source has a valid byte this cycle; deasserts after the last payload byte.
- `data_in` in 2: header address bits [1:0]. 0, 1 and 2 are valid; 3 is invalid.
- `fifo_full` in 1: the selected FIFO is full (from the synchronizer).
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-port FIFO empty.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-port read-timeout reset (from the synchronizer).
- `parity_done` in 1: the register stage has captured parity.
- `low_pkt_valid` in 1: `pkt_valid` fell while in the full phase.
- `detect_addr` out 1: header decode phase.
- `lfd_state` out 1: load the first (header) byte.
- `ld_state` out 1: load payload.
- `full_state` out 1: stalled on a full FIFO.
- `laf_state` out 1: load the byte held during the full stall.
- `write_enb_reg` out 1: FIFO write permitted.
- `rst_int_reg` out 1: clear the internal parity-error register.
- `busy` out 1: back-pressure to the source.

## Operation
There are eight states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR and WAIT_TILL_EMPTY.

Addressing:
- `addr_q` (2 bits) latches `data_in` on the DECODE_ADDRESS exit edge.
- "Selected empty" is `fifo_empty_<addr_q>`.
- "Selected soft reset" is `soft_reset_<addr_q>`.
- In DECODE_ADDRESS the empty test uses `data_in` directly.

Transitions:
- **DECODE_ADDRESS**
  - Go to LOAD_FIRST_DATA if `pkt_valid`, `data_in` ≠ 3 and that port is empty.
  - Go to WAIT_TILL_EMPTY if `pkt_valid`, `data_in` ≠ 3 and that port is not empty.
  - Otherwise stay. Address 3 is always ignored.
- **LOAD_FIRST_DATA**: go to LOAD_DATA unconditionally.
- **LOAD_DATA**, checked in this priority order:
  - `fifo_full` → FIFO_FULL_STATE.
  - else `!pkt_valid` → LOAD_PARITY.
  - else stay.
- **FIFO_FULL_STATE**: go to LOAD_AFTER_FULL when `!fifo_full`; otherwise stay.
- **LOAD_AFTER_FULL**, checked in this priority order:
  - `parity_done` → DECODE_ADDRESS.
  - else `low_pkt_valid` → LOAD_PARITY.
  - else → LOAD_DATA.
- **LOAD_PARITY**: go to CHECK_PARITY_ERROR unconditionally.
- **CHECK_PARITY_ERROR**: go to FIFO_FULL_STATE if `fifo_full`; otherwise DECODE_ADDRESS.
- **WAIT_TILL_EMPTY**: go to LOAD_FIRST_DATA when the selected FIFO is empty; otherwise stay.
- **Selected soft reset**: in any state other than DECODE_ADDRESS, forces DECODE_ADDRESS on the next edge. It overrides all other transitions.

Outputs are decoded from the state only. Any output not listed for a state is 0.
- DECODE_ADDRESS: `detect_addr`=1.
- LOAD_FIRST_DATA: `lfd_state`=1, `busy`=1.
- LOAD_DATA: `ld_state`=1, `write_enb_reg`=1, `busy`=0.
- FIFO_FULL_STATE: `full_state`=1, `busy`=1.
- LOAD_AFTER_FULL: `laf_state`=1, `write_enb_reg`=1, `busy`=1.
- LOAD_PARITY: `write_enb_reg`=1, `busy`=1.
- CHECK_PARITY_ERROR: `rst_int_reg`=1, `busy`=1.
- WAIT_TILL_EMPTY: `busy`=1.

## Timing
- **Reset**: asynchronous assertion sets state to DECODE_ADDRESS and `addr_q` to 0.
  - Reset output values: `detect_addr`=1; all other outputs 0.
  - Reset asserted mid-packet aborts the packet immediately; no write enable after assertion.
- **Output timing**: outputs change only after a clock edge (Moore, no input-to-output combinational path).
- **Minimum packet sequence**: header accepted at edge N gives the state sequence below (one state per edge), with DECODE_ADDRESS regained at N+4 when `pkt_valid` drops during the first LOAD_DATA cycle.

| Edge | State |
|---|---|
| N | LOAD_FIRST_DATA |
| N+1 | LOAD_DATA |
| N+2 | LOAD_PARITY |
| N+3 | CHECK_PARITY_ERROR |
| N+4 | DECODE_ADDRESS |

- **Full and end-of-packet together**: `fifo_full` and `!pkt_valid` in the same LOAD_DATA cycle go to FIFO_FULL_STATE (full wins).
- **`busy` in LOAD_DATA**: `busy` is 0 only in LOAD_DATA and DECODE_ADDRESS. The source may present a new byte in each LOAD_DATA cycle.
- **Soft reset with a pending wait**: soft reset and selected-empty together in WAIT_TILL_EMPTY go to DECODE_ADDRESS (soft reset wins).
- **Non-selected soft resets** are ignored.

## Structure
- Shared defines file `router_defs.vh` holds:
  - the 3-bit state encodings (binary, DECODE_ADDRESS = 3'b000);
  - `ADDR_PORT0`/`ADDR_PORT1`/`ADDR_PORT2` = 0/1/2;
  - `ADDR_INVALID` = 2'b11.
- The synchronizer and register stage include the same file.
- Single module; no sub-module is needed.
- Organised as a state register plus `addr_q`, a next-state always block, and an output decode.

## Test plan
- **Reset**: `resetn`=0 asynchronously mid-cycle → `detect_addr`=1, `busy`=0, `write_enb_reg`=0 before the next edge.
- **Normal packet**: `pkt_valid`=1, `data_in`=2'b10, `fifo_empty_2`=1 → LOAD_FIRST_DATA then LOAD_DATA. Hold `pkt_valid` for 4 cycles, then drop it → `write_enb_reg`=1 for 5 cycles (4 LOAD_DATA + LOAD_PARITY), then `rst_int_reg`=1 for 1 cycle, then `detect_addr`=1.
- **Invalid address**: `data_in`=2'b11, `pkt_valid`=1 for 10 cycles → `detect_addr` stays 1 and `busy` stays 0.
- **Busy destination**: `data_in`=2'b01, `fifo_empty_1`=0 → WAIT_TILL_EMPTY with `busy`=1. Raise `fifo_empty_1` after 6 cycles → `lfd_state`=1 on the next cycle.
- **Full stall**: assert `fifo_full` in LOAD_DATA for 3 cycles → `full_state`=1 and `write_enb_reg`=0 for 3 cycles, then `laf_state`=1. With `low_pkt_valid`=1 → LOAD_PARITY next.
- **Soft reset**: port 0 selected, assert `soft_reset_0` in FIFO_FULL_STATE → DECODE_ADDRESS next edge. `soft_reset_1` asserted in the same situation has no effect.
